// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU commands in a small FIFO, issues them one at a
// time to an external ALU with a fixed latency, and holds each captured
// result until the consumer accepts it.
module alu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_opcode,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  output logic                     alu_enable,
  output logic [3:0]               alu_opcode,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  input  logic [7:0]               alu_sum,
  input  logic                     alu_carry,
  input  logic                     alu_of,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_sum,
  output logic                     res_carry,
  output logic                     res_of,
  output logic [3:0]               res_opcode,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] WAIT_INIT = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [19:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [CW-1:0] r_wcnt;
  logic [3:0]    r_alu_op;
  logic [7:0]    r_alu_a;
  logic [7:0]    r_alu_b;
  logic          r_res_valid;
  logic [7:0]    r_res_sum;
  logic          r_res_carry;
  logic          r_res_of;
  logic [3:0]    r_res_op;

  logic w_push;
  logic w_hs;
  logic w_pop;
  logic w_capture;
  logic w_nonempty;

  // Handshake and pop/capture qualifiers; a pop happens whenever the FSM
  // is free to take the next head (IDLE, or HOLD being released).
  always_comb begin
    w_nonempty = (r_count != '0);
    w_push     = in_valid && in_ready;
    w_hs       = (r_state == S_HOLD) && res_ready;
    w_pop      = w_nonempty && ((r_state == S_IDLE) || w_hs);
    w_capture  = (r_state == S_WAIT) && (r_wcnt == '0);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_nonempty) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_wcnt == '0) w_next = S_HOLD;
      S_HOLD:  if (res_ready) w_next = w_nonempty ? S_ISSUE : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs; in_ready drops while reset is asserted and whenever full.
  always_comb begin
    alu_enable = (r_state == S_ISSUE);
    in_ready   = (r_count < FULL_CNT) && reset;
  end

  // Command FIFO: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {in_opcode, in_a, in_b};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Operand, wait-counter and result registers. Operands load only on a
  // pop, so they stay put from ISSUE through the capture edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_wcnt      <= '0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_carry <= 1'b0;
      r_res_of    <= 1'b0;
      r_res_op    <= '0;
    end else begin
      if (w_pop) {r_alu_op, r_alu_a, r_alu_b} <= r_mem[r_rptr];
      if (r_state == S_ISSUE)                       r_wcnt <= WAIT_INIT;
      else if (r_state == S_WAIT && r_wcnt != '0)   r_wcnt <= r_wcnt - 1'b1;
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_sum   <= alu_sum;
        r_res_carry <= alu_carry;
        r_res_of    <= alu_of;
        r_res_op    <= r_alu_op;
      end else if (w_hs) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign alu_opcode = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign res_valid  = r_res_valid;
  assign res_sum    = r_res_sum;
  assign res_carry  = r_res_carry;
  assign res_of     = r_res_of;
  assign res_opcode = r_res_op;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: randomized traffic against a queue/timer
// reference model (ALU_LAT=1), plus a directed single-op run at ALU_LAT=3.
module tb_alu_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;
  localparam int LAT3  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // ---------------- ALU model: valid only ALU_LAT cycles after enable ----
  function automatic logic [9:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [8:0] t;
    logic       c;
    logic [7:0] s;
    case (op[1:0])
      2'd0:    begin t = {1'b0, a} + {1'b0, b}; s = t[7:0]; c = t[8]; end
      2'd1:    begin t = {1'b0, a} - {1'b0, b}; s = t[7:0]; c = t[8]; end
      2'd2:    begin s = a & b; c = 1'b0; end
      default: begin s = a ^ b; c = |op[3:2]; end
    endcase
    return {s[7] ^ c, c, s};
  endfunction

  // ---------------- DUT (ALU_LAT=1) ----------------
  logic       reset, in_valid, in_ready, alu_enable, res_valid, res_ready;
  logic [3:0] in_opcode, alu_opcode, res_opcode;
  logic [7:0] in_a, in_b, alu_a, alu_b, alu_sum, res_sum;
  logic       alu_carry, alu_of, res_carry, res_of;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [7:0] en_sh = '0;
  logic [9:0] w_f;

  alu_issue_ctrl #(.DEPTH(DEPTH), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sum(alu_sum), .alu_carry(alu_carry), .alu_of(alu_of),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_carry(res_carry), .res_of(res_of), .res_opcode(res_opcode),
    .fifo_count(fifo_count));

  always @(posedge clk) en_sh <= {en_sh[6:0], alu_enable};
  assign w_f = alu_f(alu_opcode, alu_a, alu_b);
  assign {alu_of, alu_carry, alu_sum} = en_sh[LAT-1] ? w_f : ~w_f;

  // ---------------- DUT (ALU_LAT=3) ----------------
  logic       reset3, in_valid3, in_ready3, alu_enable3, res_valid3, res_ready3;
  logic [3:0] in_opcode3, alu_opcode3, res_opcode3;
  logic [7:0] in_a3, in_b3, alu_a3, alu_b3, alu_sum3, res_sum3;
  logic       alu_carry3, alu_of3, res_carry3, res_of3;
  logic [$clog2(DEPTH):0] fifo_count3;
  logic [7:0] en_sh3 = '0;
  logic [9:0] w_f3;

  alu_issue_ctrl #(.DEPTH(DEPTH), .ALU_LAT(LAT3)) u_dut3 (
    .clk(clk), .reset(reset3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_opcode(in_opcode3), .in_a(in_a3), .in_b(in_b3),
    .alu_enable(alu_enable3), .alu_opcode(alu_opcode3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_sum(alu_sum3), .alu_carry(alu_carry3), .alu_of(alu_of3),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_sum(res_sum3),
    .res_carry(res_carry3), .res_of(res_of3), .res_opcode(res_opcode3),
    .fifo_count(fifo_count3));

  always @(posedge clk) en_sh3 <= {en_sh3[6:0], alu_enable3};
  assign w_f3 = alu_f(alu_opcode3, alu_a3, alu_b3);
  assign {alu_of3, alu_carry3, alu_sum3} = en_sh3[LAT3-1] ? w_f3 : ~w_f3;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // q holds queued commands; cur is the command handed to the ALU; tmr counts
  // edges until its result becomes visible (ISSUE + ALU_LAT wait cycles).
  logic [19:0] q[$];
  logic [19:0] m_cur;
  bit          m_busy, m_valid, m_fresh;
  int          m_tmr;
  int          n_res;

  task automatic model_edge();
    bit acc, hs, pop;
    if (!reset) begin
      q.delete();
      m_busy = 0; m_valid = 0; m_fresh = 1; m_tmr = 0; m_cur = '0;
    end else begin
      acc = in_valid && (q.size() < DEPTH);
      hs  = m_valid && res_ready;
      pop = (q.size() != 0) && (!m_busy || hs);
      if (hs) begin
        m_valid = 0; m_busy = 0; n_res++;
      end else if (m_busy && !m_valid) begin
        m_tmr--;
        if (m_tmr == 0) m_valid = 1;
      end
      if (pop) begin
        m_cur = q.pop_front(); m_busy = 1; m_tmr = LAT + 1; m_fresh = 0;
      end
      if (acc) q.push_back({in_opcode, in_a, in_b});
    end
  endtask

  task automatic model_check();
    logic [9:0] r;
    r = alu_f(m_cur[19:16], m_cur[15:8], m_cur[7:0]);
    check("in_ready",   32'(in_ready),   32'(reset && (q.size() < DEPTH)));
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("res_valid",  32'(res_valid),  32'(m_valid));
    check("alu_enable", 32'(alu_enable), 32'(m_busy && !m_valid && m_tmr == LAT + 1));
    if (m_busy)
      check("alu_ops", {12'h0, alu_opcode, alu_a, alu_b}, {12'h0, m_cur});
    if (m_valid)
      check("result", {18'h0, res_opcode, res_of, res_carry, res_sum},
                      {18'h0, m_cur[19:16], r});
    if (m_fresh)
      check("zeroed", {7'h0, res_opcode, res_of, res_carry, res_sum, alu_opcode, alu_a, alu_b},
                      32'h0);
  endtask

  // One clock: inputs applied at the negedge, model advanced at the posedge,
  // outputs compared at the following negedge.
  task automatic step(input bit v, input bit rr, input bit rst_n,
                      input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = v; res_ready = rr; reset = rst_n;
    in_opcode = op; in_a = a; in_b = b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic rstep(input int pv, input int pr, input int prst);
    step(($urandom % 100) < pv, ($urandom % 100) < pr, ($urandom % 1000) >= prst,
         4'($urandom), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    reset = 0; in_valid = 0; res_ready = 0; in_opcode = 0; in_a = 0; in_b = 0;
    reset3 = 0; in_valid3 = 0; res_ready3 = 0; in_opcode3 = 0; in_a3 = 0; in_b3 = 0;
    n_res = 0; m_fresh = 1;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // single op
    step(1, 1, 1, 4'h0, 8'h99, 8'h48);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0, 0);
    check("single_res_count", 32'(n_res), 32'd1);
    // fill with consumer stalled, then drain
    for (int i = 0; i < 16; i++) rstep(100, 0, 0);
    check("full_count", 32'(fifo_count), 32'(DEPTH));
    for (int i = 0; i < 30; i++) rstep(0, 100, 0);
    // streaming with consumer always ready
    for (int i = 0; i < 8; i++) step(1, 1, 1, 4'(i), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 40; i++) rstep(0, 100, 0);
    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) rstep(60, 40, 15);
    for (int i = 0; i < 500; i++) rstep(90, 90, 5);
    check("results_seen", 32'(n_res > 50), 32'd1);

    // ---------------- ALU_LAT=3 single op ----------------
    @(negedge clk); reset3 = 1;
    in_valid3 = 1; in_opcode3 = 4'h0; in_a3 = 8'h99; in_b3 = 8'h48;
    @(posedge clk);
    @(negedge clk); in_valid3 = 0;
    for (int k = 1; k <= 9; k++) begin
      check("lat3_enable", 32'(alu_enable3), 32'(k == 2));
      check("lat3_valid",  32'(res_valid3),  32'(k >= 6));
      if (k >= 2) check("lat3_ops", {16'h0, alu_a3, alu_b3}, 32'h9948);
      if (k == 6) check("lat3_sum", {22'h0, res_of3, res_carry3, res_sum3},
                        32'(alu_f(4'h0, 8'h99, 8'h48)));
      @(negedge clk);
    end
    res_ready3 = 1;
    @(negedge clk);
    check("lat3_release", 32'(res_valid3), 32'd0);
    check("lat3_empty",   32'(fifo_count3), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
